// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the Johnson-counter sequencer and any block that
// consumes its phase outputs.
//   - seq_state_t    : sequencer control states
//   - DEFAULT_*      : default ring / revolution-counter widths
//   - ring_vec_t     : wide carrier so the helpers work for any ring width
//   - is_legal()     : true when a ring value is one of the 2*width Johnson codes
//   - next_q()       : one twisted-ring shift step
// -----------------------------------------------------------------------------
package johnson_pkg;

  localparam int DEFAULT_WIDTH = 5;
  localparam int DEFAULT_CNT_W = 8;

  // Upper bound on ring width supported by the helper functions.
  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] ring_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // A Johnson code is a block of ones anchored at one end of the ring, so
  // neighbouring bits differ at most once. Any value with two or more
  // transitions cannot be reached by shifting and is therefore illegal.
  function automatic logic is_legal(input ring_vec_t q, input int width);
    int edges;
    edges = 0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if ((i < width - 1) && (q[i] != q[i+1])) begin
        edges++;
      end
    end
    return (edges <= 1);
  endfunction

  // Twisted-ring shift: every stage takes its lower neighbour, and the first
  // stage takes the inverse of the last one.
  function automatic ring_vec_t next_q(input ring_vec_t q, input int width);
    ring_vec_t r;
    r = '0;
    for (int i = 1; i < MAX_W; i++) begin
      if (i < width) begin
        r[i] = q[i-1];
      end
    end
    r[0] = ~q[width-1];
    return r;
  endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// -----------------------------------------------------------------------------
// johnson_phase_decode
// Purely combinational decode of a Johnson ring value into a one-hot phase.
// Kept separate so other phase consumers can decode the same ring without
// duplicating the legality rules.
// Ports:
//   q     in  WIDTH    ring state, q[0] is the first stage
//   phase out 2*WIDTH  one-hot phase index, all zero when q is illegal
//   legal out 1        q is one of the 2*WIDTH Johnson codes
// -----------------------------------------------------------------------------
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] phase,
  output logic               legal
);

  localparam logic [2*WIDTH-1:0] PHASE_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  int ones;
  int k;

  // The first half of the sequence fills with ones from the bottom, so the
  // phase index is the ones count. Once the top stage is set the ring drains
  // from the bottom, and the index counts down from 2*WIDTH instead.
  always_comb begin
    legal = is_legal(ring_vec_t'(q), WIDTH);
    ones  = $countones(q);
    k     = q[WIDTH-1] ? (2 * WIDTH - ones) : ones;
    phase = legal ? (PHASE_ONE << k) : '0;
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// johnson_seq_ctrl
// Runs a WIDTH-stage Johnson ring for a programmed number of full revolutions,
// advancing one phase per step_en, and flags/recovers illegal ring values.
// Ports:
//   clock    in  1        rising-edge clock
//   reset    in  1        synchronous active-high reset
//   start    in  1        begin a sequence (honoured in IDLE)
//   stop     in  1        abort a sequence (honoured in RUN)
//   num_rev  in  CNT_W    revolutions to run, captured on an accepted start
//   step_en  in  1        advance one phase this cycle (RUN only)
//   load     in  1        preload the ring (IDLE only, start wins)
//   load_val in  WIDTH    preload value
//   q        out WIDTH    ring state
//   phase    out 2*WIDTH  one-hot phase decode of q
//   rev_cnt  out CNT_W    revolutions completed in the current/last run
//   busy     out 1        sequencer is running
//   done     out 1        single-cycle completion pulse
//   err      out 1        sticky illegal-state flag
// -----------------------------------------------------------------------------
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   num_rev,
  input  logic               step_en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] phase,
  output logic [CNT_W-1:0]   rev_cnt,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // Last code before the ring wraps to all zeros: top stage set, rest clear.
  localparam logic [WIDTH-1:0] WRAP_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] rev_cnt_inc;
  logic [WIDTH-1:0] q_shift;
  logic             legal;
  logic             start_ok;
  logic             step_ok;
  logic             rev_step;
  logic             last_rev;

  johnson_phase_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .q     (q),
    .phase (phase),
    .legal (legal)
  );

  // Qualified control events. An illegal ring value blocks every normal
  // action for one edge so that the recovery to zero is all that happens.
  always_comb begin
    q_shift     = WIDTH'(next_q(ring_vec_t'(q), WIDTH));
    rev_cnt_inc = rev_cnt + CNT_W'(1);
    start_ok    = (state == IDLE) && legal && start;
    step_ok     = (state == RUN) && legal && !stop && step_en;
    rev_step    = step_ok && (q == WRAP_CODE);
    last_rev    = rev_step && (rev_cnt_inc == target);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero revolution request skips straight to DONE so the
  // caller still sees a completion pulse. Stop takes precedence over stepping.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = (num_rev != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (legal && stop) begin
          state_next = IDLE;
        end else if (last_rev) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs depend on state only, so they are glitch-free registers'
  // decode rather than combinations of the inputs.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Ring, revolution counter, target and error flag. Illegal recovery sits
  // above the per-state behaviour so a corrupted ring is always cleared on
  // the very next edge, whatever the sequencer is doing.
  always_ff @(posedge clock) begin
    if (reset) begin
      q       <= '0;
      rev_cnt <= '0;
      target  <= '0;
      err     <= 1'b0;
    end else if (!legal) begin
      q   <= '0;
      err <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            target  <= num_rev;
            rev_cnt <= '0;
            err     <= 1'b0;
          end else if (load) begin
            q <= load_val;
          end
        end
        RUN: begin
          if (stop) begin
            q <= '0;
          end else if (step_en) begin
            q <= q_shift;
            if (rev_step) begin
              rev_cnt <= rev_cnt_inc;
            end
          end
        end
        default: begin
          q <= q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_johnson_seq_ctrl
// Scoreboard bench: the driver applies one set of inputs per cycle, advances a
// phase-index reference model and queues the outputs expected after the next
// edge; an independent monitor pops and compares them each cycle.
// -----------------------------------------------------------------------------
module tb_johnson_seq_ctrl;

  localparam int W  = 5;
  localparam int CW = 8;
  localparam int PH = 2 * W;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [CW-1:0] num_rev;
  logic          step_en;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [PH-1:0] phase;
  logic [CW-1:0] rev_cnt;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clock = ~clock;

  johnson_seq_ctrl #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .num_rev  (num_rev),
    .step_en  (step_en),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .phase    (phase),
    .rev_cnt  (rev_cnt),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    logic [W-1:0]  q;
    logic [PH-1:0] phase;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] rev;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position in the sequence as an integer index (-1 when the
  // ring holds a value that is not in the sequence), plus mode 0/1/2 for
  // idle/run/done.
  logic [W-1:0] pat [PH];
  int           m_idx;
  logic [W-1:0] m_raw;
  int           m_mode;
  bit           m_err;
  int           m_rev;
  int           m_target;

  // Sequence code k: k ones from the bottom for k<=W, then ones drain away
  // from the bottom, leaving the top PH-k stages set.
  function automatic void build_patterns();
    int v;
    for (int k = 0; k < PH; k++) begin
      if (k <= W) v = (1 << k) - 1;
      else        v = ~((1 << (k - W)) - 1);
      pat[k] = W'(v);
    end
  endfunction

  function automatic int find_idx(input logic [W-1:0] v);
    for (int k = 0; k < PH; k++) begin
      if (pat[k] == v) return k;
    end
    return -1;
  endfunction

  function automatic void model_step(input bit r, input bit st, input bit sp,
                                     input int nr, input bit se, input bit ld,
                                     input logic [W-1:0] lv);
    if (r) begin
      m_idx = 0; m_mode = 0; m_err = 0; m_rev = 0; m_target = 0;
    end else if (m_idx < 0) begin
      m_idx = 0;
      m_err = 1;
      if (m_mode == 2) m_mode = 0;
    end else begin
      case (m_mode)
        0: begin
          if (st) begin
            m_err = 0; m_rev = 0; m_target = nr;
            m_mode = (nr != 0) ? 1 : 2;
          end else if (ld) begin
            m_idx = find_idx(lv);
            m_raw = lv;
          end
        end
        1: begin
          if (sp) begin
            m_idx = 0; m_mode = 0;
          end else if (se) begin
            if (m_idx == PH - 1) begin
              m_rev++;
              if (m_rev == m_target) m_mode = 2;
            end
            m_idx = (m_idx + 1) % PH;
          end
        end
        default: m_mode = 0;
      endcase
    end
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e.q     = (m_idx >= 0) ? pat[m_idx] : m_raw;
    e.phase = (m_idx >= 0) ? (PH'(1) << m_idx) : '0;
    e.busy  = (m_mode == 1);
    e.done  = (m_mode == 2);
    e.err   = m_err;
    e.rev   = CW'(m_rev);
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the DUT should show after it.
  task automatic apply_stimulus(input bit r, input bit st, input bit sp,
                                input int nr, input bit se, input bit ld,
                                input logic [W-1:0] lv);
    @(negedge clock);
    reset    = r;
    start    = st;
    stop     = sp;
    num_rev  = CW'(nr);
    step_en  = se;
    load     = ld;
    load_val = lv;
    model_step(r, st, sp, nr, se, ld, lv);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, '0);
  endtask

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Monitor: compares every cycle, 1 time unit after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("q",       32'(q),       32'(e.q));
        check_output("phase",   32'(phase),   32'(e.phase));
        check_output("busy",    32'(busy),    32'(e.busy));
        check_output("done",    32'(done),    32'(e.done));
        check_output("err",     32'(err),     32'(e.err));
        check_output("rev_cnt", 32'(rev_cnt), 32'(e.rev));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] lv;
    reset = 1'b1; start = 1'b0; stop = 1'b0; num_rev = '0;
    step_en = 1'b0; load = 1'b0; load_val = '0;
    build_patterns();
    m_idx = 0; m_raw = '0; m_mode = 0; m_err = 0; m_rev = 0; m_target = 0;

    $display("[TB] reset");
    apply_stimulus(1, 0, 0, 0, 0, 0, '0);
    apply_stimulus(1, 0, 0, 0, 0, 0, '0);

    $display("[TB] two revolutions, continuous stepping");
    apply_stimulus(0, 1, 0, 2, 0, 0, '0);
    for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 0, 1, 0, '0);
    idle_cycles(3);

    $display("[TB] one revolution, step_en toggling");
    apply_stimulus(0, 1, 0, 1, 0, 0, '0);
    for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 0, (i % 2) == 0, 0, '0);
    idle_cycles(3);

    $display("[TB] stop after seven steps");
    apply_stimulus(0, 1, 0, 3, 0, 0, '0);
    for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 0, 0, 1, 0, '0);
    apply_stimulus(0, 0, 1, 0, 1, 0, '0);
    idle_cycles(3);

    $display("[TB] illegal preload and recovery");
    apply_stimulus(0, 0, 0, 0, 0, 1, 5'b00101);
    idle_cycles(3);

    $display("[TB] zero revolutions, then start ignored mid-run");
    apply_stimulus(0, 1, 0, 0, 0, 0, '0);
    idle_cycles(2);
    apply_stimulus(0, 1, 0, 1, 0, 0, '0);
    for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 0, 2, 1, 1, 5'b01010);
    idle_cycles(3);

    $display("[TB] legal preload then reset mid-run");
    apply_stimulus(0, 0, 0, 0, 0, 1, 5'b00111);
    apply_stimulus(0, 1, 0, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 0, 1, 0, '0);
    apply_stimulus(1, 0, 0, 0, 1, 0, '0);
    idle_cycles(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      lv = ($urandom_range(0, 1) == 0) ? pat[$urandom_range(0, PH - 1)] : W'($urandom);
      apply_stimulus($urandom_range(0, 99) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 15) == 0,
                     int'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 7) == 0,
                     lv);
    end
    idle_cycles(2);

    @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
